// File: rtl/mem_req_arbiter.sv
// Memory request arbiter between the icache and dcache subsystems and a
// single-ported main memory. Grants the command port to one requester per
// cycle, tracks which side owns each outstanding load tag, and steers
// returning data to the owner. A starvation counter forces icache progress
// under sustained dcache traffic.

`ifndef NUM_MEM_TAGS
`define NUM_MEM_TAGS 15
`endif

package mem_req_arbiter_pkg;

    localparam int NUM_MEM_TAGS = `NUM_MEM_TAGS;
    localparam int ADDR_W       = 32;
    localparam int BLOCK_W      = 64;
    localparam int TAG_W        = $clog2(NUM_MEM_TAGS + 1);

    typedef logic [ADDR_W-1:0]  ADDR;
    typedef logic [BLOCK_W-1:0] MEM_BLOCK;
    typedef logic [TAG_W-1:0]   MEM_TAG;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'h0,
        MEM_LOAD  = 2'h1,
        MEM_STORE = 2'h2
    } MEM_COMMAND;

    typedef struct packed {
        logic valid;
        ADDR  addr;
    } ADDR_PACKET;

endpackage

module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int NUM_TAGS     = NUM_MEM_TAGS,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_BITS     = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                          clock,
    input  logic                          reset,

    // icache side
    input  ADDR_PACKET                    icache_req,
    output MEM_TAG                        icache_req_tag,
    output logic                          icache_req_accepted,
    output MEM_BLOCK                      icache_data,
    output MEM_TAG                        icache_data_tag,

    // dcache side
    input  logic                          dcache_req_valid,
    input  MEM_COMMAND                    dcache_req_cmd,
    input  ADDR                           dcache_req_addr,
    input  MEM_BLOCK                      dcache_req_data,
    output MEM_TAG                        dcache_req_tag,
    output logic                          dcache_req_accepted,
    output MEM_BLOCK                      dcache_data,
    output MEM_TAG                        dcache_data_tag,

    // main memory side
    output MEM_COMMAND                    proc2mem_command,
    output ADDR                           proc2mem_addr,
    output MEM_BLOCK                      proc2mem_data,
    input  MEM_TAG                        mem2proc_transaction_tag,
    input  MEM_BLOCK                      mem2proc_data,
    input  MEM_TAG                        mem2proc_data_tag,

    // status
    output logic [$clog2(NUM_TAGS+1)-1:0] outstanding_count,
    output logic                          spurious_return
);

    localparam int OCNT_W = $clog2(NUM_TAGS + 1);

    // Starvation counter and owner table state
    logic [CNT_BITS-1:0] starve_cnt_reg;
    logic [CNT_BITS-1:0] starve_cnt_next;
    logic [NUM_TAGS-1:0] valid_reg;
    logic [NUM_TAGS-1:0] valid_next;
    logic [NUM_TAGS-1:0] owner_d_reg;
    logic [NUM_TAGS-1:0] owner_d_next;
    logic [OCNT_W-1:0]   count_reg;
    logic [OCNT_W-1:0]   count_next;

    // Arbitration and table-update controls
    logic                icache_prio;
    logic                grant_i;
    logic                grant_d;
    logic                mem_accepted;
    logic                alloc;
    logic [NUM_TAGS-1:0] ret_hit;
    logic [NUM_TAGS-1:0] alloc_hit;
    logic                ret_valid;
    logic                ret_owner_d;

    // icache only overrides dcache once it has been denied STARVE_LIMIT
    // consecutive cycles; otherwise dcache has priority.
    assign icache_prio  = (starve_cnt_reg == CNT_BITS'(STARVE_LIMIT)) && icache_req.valid;
    assign grant_i      = icache_req.valid && (icache_prio || !dcache_req_valid);
    assign grant_d      = dcache_req_valid && !grant_i;
    assign mem_accepted = (mem2proc_transaction_tag != '0);

    // Only accepted loads need a return path; stores never allocate.
    assign alloc = mem_accepted &&
                   (grant_i || (grant_d && (dcache_req_cmd == MEM_LOAD)));

    // Command port mux and accept/tag pass-through to the winner
    always_comb begin
        proc2mem_command    = MEM_NONE;
        proc2mem_addr       = '0;
        proc2mem_data       = '0;
        icache_req_tag      = '0;
        icache_req_accepted = 1'b0;
        dcache_req_tag      = '0;
        dcache_req_accepted = 1'b0;
        if (grant_i) begin
            proc2mem_command    = MEM_LOAD;
            proc2mem_addr       = icache_req.addr;
            icache_req_tag      = mem2proc_transaction_tag;
            icache_req_accepted = mem_accepted;
        end else if (grant_d) begin
            proc2mem_command    = dcache_req_cmd;
            proc2mem_addr       = dcache_req_addr;
            if (dcache_req_cmd == MEM_STORE) begin
                proc2mem_data = dcache_req_data;
            end
            dcache_req_tag      = mem2proc_transaction_tag;
            dcache_req_accepted = mem_accepted;
        end
    end

    // Per-entry match and next-state. A return clears the entry and an
    // allocation of the same tag in the same cycle then re-sets it, so the
    // entry ends valid with the new owner.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_TAGS; gi++) begin : g_entry
            assign ret_hit[gi]      = valid_reg[gi] &&
                                      (mem2proc_data_tag == MEM_TAG'(gi + 1));
            assign alloc_hit[gi]    = alloc &&
                                      (mem2proc_transaction_tag == MEM_TAG'(gi + 1));
            assign valid_next[gi]   = alloc_hit[gi] || (valid_reg[gi] && !ret_hit[gi]);
            assign owner_d_next[gi] = alloc_hit[gi] ? grant_d : owner_d_reg[gi];
        end
    endgenerate

    assign ret_valid   = |ret_hit;
    assign ret_owner_d = |(ret_hit & owner_d_reg);

    // Return routing: only the owning side sees the data and tag
    always_comb begin
        icache_data     = '0;
        icache_data_tag = '0;
        dcache_data     = '0;
        dcache_data_tag = '0;
        if (ret_valid) begin
            if (ret_owner_d) begin
                dcache_data     = mem2proc_data;
                dcache_data_tag = mem2proc_data_tag;
            end else begin
                icache_data     = mem2proc_data;
                icache_data_tag = mem2proc_data_tag;
            end
        end
    end

    // A nonzero return with no owner is flagged; suppressed while in reset.
    assign spurious_return = reset && (mem2proc_data_tag != '0) && !ret_valid;

    // Starvation counter next-state: saturating count of denied icache cycles
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!icache_req.valid || icache_req_accepted) begin
            starve_cnt_next = '0;
        end else if (starve_cnt_reg != CNT_BITS'(STARVE_LIMIT)) begin
            starve_cnt_next = starve_cnt_reg + 1'b1;
        end
    end

    // Popcount of the next table so the registered count tracks the table
    always_comb begin
        count_next = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            count_next = count_next + OCNT_W'(valid_next[i]);
        end
    end

    assign outstanding_count = count_reg;

    // State registers; reset discards all ownership
    always_ff @(posedge clock) begin
        if (!reset) begin
            starve_cnt_reg <= '0;
            valid_reg      <= '0;
            owner_d_reg    <= '0;
            count_reg      <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            valid_reg      <= valid_next;
            owner_d_reg    <= owner_d_next;
            count_reg      <= count_next;
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: a behavioural model predicts each
// cycle's outputs, pushes them to a scoreboard queue when stimulus is driven,
// and pops/compares them once the DUT outputs have settled.

module tb_mem_req_arbiter;
    import mem_req_arbiter_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    ADDR_PACKET icache_req;
    MEM_TAG     icache_req_tag;
    logic       icache_req_accepted;
    MEM_BLOCK   icache_data;
    MEM_TAG     icache_data_tag;
    logic       dcache_req_valid;
    MEM_COMMAND dcache_req_cmd;
    ADDR        dcache_req_addr;
    MEM_BLOCK   dcache_req_data;
    MEM_TAG     dcache_req_tag;
    logic       dcache_req_accepted;
    MEM_BLOCK   dcache_data;
    MEM_TAG     dcache_data_tag;
    MEM_COMMAND proc2mem_command;
    ADDR        proc2mem_addr;
    MEM_BLOCK   proc2mem_data;
    MEM_TAG     mem2proc_transaction_tag;
    MEM_BLOCK   mem2proc_data;
    MEM_TAG     mem2proc_data_tag;
    logic [3:0] outstanding_count;
    logic       spurious_return;

    always #5 clock = ~clock;

    mem_req_arbiter dut (
        .clock                    (clock),
        .reset                    (reset),
        .icache_req               (icache_req),
        .icache_req_tag           (icache_req_tag),
        .icache_req_accepted      (icache_req_accepted),
        .icache_data              (icache_data),
        .icache_data_tag          (icache_data_tag),
        .dcache_req_valid         (dcache_req_valid),
        .dcache_req_cmd           (dcache_req_cmd),
        .dcache_req_addr          (dcache_req_addr),
        .dcache_req_data          (dcache_req_data),
        .dcache_req_tag           (dcache_req_tag),
        .dcache_req_accepted      (dcache_req_accepted),
        .dcache_data              (dcache_data),
        .dcache_data_tag          (dcache_data_tag),
        .proc2mem_command         (proc2mem_command),
        .proc2mem_addr            (proc2mem_addr),
        .proc2mem_data            (proc2mem_data),
        .mem2proc_transaction_tag (mem2proc_transaction_tag),
        .mem2proc_data            (mem2proc_data),
        .mem2proc_data_tag        (mem2proc_data_tag),
        .outstanding_count        (outstanding_count),
        .spurious_return          (spurious_return)
    );

    typedef struct {
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [63:0] pdata;
        logic [3:0]  itag;
        logic        iacc;
        logic [3:0]  dtag;
        logic        dacc;
        logic [3:0]  idtag;
        logic [63:0] idata;
        logic [3:0]  ddtag;
        logic [63:0] ddata;
        logic        spur;
        logic [3:0]  cnt;
    } exp_t;

    exp_t exp_q[$];

    int tests_run    = 0;
    int tests_failed = 0;

    // Model state
    bit m_valid   [15];
    bit m_owner_d [15];
    int m_starve = 0;
    int m_count  = 0;

    // Last observed values, for targeted checks after a step
    logic [1:0]  obs_cmd;
    logic [31:0] obs_addr;
    logic [63:0] obs_pdata;
    logic [3:0]  obs_itag, obs_dtag, obs_idtag, obs_ddtag, obs_cnt;
    logic [63:0] obs_idata;
    logic        obs_iacc, obs_dacc, obs_spur;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle of stimulus with model prediction and comparison
    task automatic step(input bit rst_n, input bit iv, input logic [31:0] ia,
                        input bit dv, input MEM_COMMAND dc, input logic [31:0] da,
                        input logic [63:0] dd, input logic [3:0] tt,
                        input logic [3:0] rt, input logic [63:0] rd);
        exp_t e;
        exp_t o;
        bit   prio, g_i, g_d, acc, alloc;
        int   k;
        @(negedge clock);
        reset                    = rst_n;
        icache_req.valid         = iv;
        icache_req.addr          = ia;
        dcache_req_valid         = dv;
        dcache_req_cmd           = dc;
        dcache_req_addr          = da;
        dcache_req_data          = dd;
        mem2proc_transaction_tag = tt;
        mem2proc_data_tag        = rt;
        mem2proc_data            = rd;

        prio = (m_starve == 4) && iv;
        g_i  = iv && (prio || !dv);
        g_d  = dv && !g_i;
        acc  = (tt != 4'd0);
        e.cmd   = g_i ? 2'(MEM_LOAD) : (g_d ? 2'(dc) : 2'(MEM_NONE));
        e.addr  = g_i ? ia : (g_d ? da : 32'd0);
        e.pdata = (g_d && dc == MEM_STORE) ? dd : 64'd0;
        e.itag  = g_i ? tt : 4'd0;
        e.iacc  = g_i && acc;
        e.dtag  = g_d ? tt : 4'd0;
        e.dacc  = g_d && acc;
        e.idtag = 4'd0;
        e.idata = 64'd0;
        e.ddtag = 4'd0;
        e.ddata = 64'd0;
        e.spur  = 1'b0;
        e.cnt   = 4'(m_count);
        if (rt != 4'd0) begin
            k = int'(rt) - 1;
            if (m_valid[k]) begin
                if (m_owner_d[k]) begin
                    e.ddtag = rt;
                    e.ddata = rd;
                end else begin
                    e.idtag = rt;
                    e.idata = rd;
                end
            end else begin
                e.spur = rst_n;
            end
        end
        exp_q.push_back(e);

        #1;
        o = exp_q.pop_front();
        check_val("cmd",       64'(proc2mem_command),    64'(o.cmd));
        check_val("addr",      64'(proc2mem_addr),       64'(o.addr));
        check_val("pdata",     64'(proc2mem_data),       o.pdata);
        check_val("i_req_tag", 64'(icache_req_tag),      64'(o.itag));
        check_val("i_acc",     64'(icache_req_accepted), 64'(o.iacc));
        check_val("d_req_tag", 64'(dcache_req_tag),      64'(o.dtag));
        check_val("d_acc",     64'(dcache_req_accepted), 64'(o.dacc));
        check_val("i_dtag",    64'(icache_data_tag),     64'(o.idtag));
        check_val("i_data",    icache_data,              o.idata);
        check_val("d_dtag",    64'(dcache_data_tag),     64'(o.ddtag));
        check_val("d_data",    dcache_data,              o.ddata);
        check_val("spurious",  64'(spurious_return),     64'(o.spur));
        check_val("out_cnt",   64'(outstanding_count),   64'(o.cnt));

        obs_cmd   = proc2mem_command;
        obs_addr  = proc2mem_addr;
        obs_pdata = proc2mem_data;
        obs_itag  = icache_req_tag;
        obs_iacc  = icache_req_accepted;
        obs_dtag  = dcache_req_tag;
        obs_dacc  = dcache_req_accepted;
        obs_idtag = icache_data_tag;
        obs_idata = icache_data;
        obs_ddtag = dcache_data_tag;
        obs_spur  = spurious_return;
        obs_cnt   = outstanding_count;

        $display("[TB] t=%0t rst_n=%0b cmd=%0d addr=%h itag=%0d iacc=%0b dtag=%0d dacc=%0b ret_i=%0d ret_d=%0d spur=%0b cnt=%0d",
                 $time, rst_n, proc2mem_command, proc2mem_addr, icache_req_tag, icache_req_accepted,
                 dcache_req_tag, dcache_req_accepted, icache_data_tag, dcache_data_tag,
                 spurious_return, outstanding_count);

        // Advance the model to the state after the coming clock edge
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) m_valid[i] = 1'b0;
            m_starve = 0;
        end else begin
            if (rt != 4'd0 && m_valid[int'(rt) - 1]) m_valid[int'(rt) - 1] = 1'b0;
            alloc = acc && (g_i || (g_d && dc == MEM_LOAD));
            if (alloc) begin
                assert (!m_valid[int'(tt) - 1])
                    else $error("[TB] FAIL realloc: tag %0d allocated while still outstanding", tt);
                m_valid[int'(tt) - 1]   = 1'b1;
                m_owner_d[int'(tt) - 1] = g_d;
            end
            if (!iv || (g_i && acc)) m_starve = 0;
            else if (m_starve < 4)   m_starve++;
        end
        m_count = 0;
        for (int i = 0; i < 15; i++) m_count += int'(m_valid[i]);
    endtask

    task automatic idle(input logic [3:0] rt, input logic [63:0] rd);
        step(1'b1, 1'b0, 32'd0, 1'b0, MEM_NONE, 32'd0, 64'd0, 4'd0, rt, rd);
    endtask

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, time %0t required below 100000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset                    = 1'b0;
        icache_req               = '0;
        dcache_req_valid         = 1'b0;
        dcache_req_cmd           = MEM_NONE;
        dcache_req_addr          = '0;
        dcache_req_data          = '0;
        mem2proc_transaction_tag = '0;
        mem2proc_data            = '0;
        mem2proc_data_tag        = '0;

        // Reset held with both requesting and memory offering tag 3
        for (int c = 0; c < 2; c++) begin
            step(1'b0, 1'b1, 32'h2000, 1'b1, MEM_LOAD, 32'h3000, 64'd0, 4'd3, 4'd0, 64'd0);
            check_val("rst_cnt",  64'(obs_cnt),  64'd0);
            check_val("rst_spur", 64'(obs_spur), 64'd0);
        end
        step(1'b1, 1'b1, 32'h2000, 1'b1, MEM_LOAD, 32'h3000, 64'd0, 4'd3, 4'd0, 64'd0);
        check_val("post_rst_cnt",  64'(obs_cnt),  64'd0);
        check_val("post_rst_dtag", 64'(obs_dtag), 64'd3);
        check_val("post_rst_iacc", 64'(obs_iacc), 64'd0);
        idle(4'd3, 64'h55);
        check_val("ret3_dtag", 64'(obs_ddtag), 64'd3);

        // icache load alone, data back three cycles later
        step(1'b1, 1'b1, 32'h1000, 1'b0, MEM_NONE, 32'd0, 64'd0, 4'd5, 4'd0, 64'd0);
        check_val("i_load_cmd",  64'(obs_cmd),  64'(MEM_LOAD));
        check_val("i_load_addr", 64'(obs_addr), 64'h1000);
        check_val("i_load_acc",  64'(obs_iacc), 64'd1);
        check_val("i_load_tag",  64'(obs_itag), 64'd5);
        idle(4'd0, 64'd0);
        check_val("i_load_cnt1", 64'(obs_cnt), 64'd1);
        idle(4'd0, 64'd0);
        idle(4'd5, 64'hDEADBEEF_CAFEF00D);
        check_val("i_ret_tag",   64'(obs_idtag), 64'd5);
        check_val("i_ret_data",  obs_idata,      64'hDEADBEEF_CAFEF00D);
        check_val("i_ret_dtag0", 64'(obs_ddtag), 64'd0);
        idle(4'd0, 64'd0);
        check_val("i_ret_cnt0",  64'(obs_cnt), 64'd0);

        // Both requesting continuously: dcache wins four cycles, then icache
        for (int c = 0; c < 5; c++) begin
            step(1'b1, 1'b1, 32'h2000 + 32'(c * 64), 1'b1, MEM_LOAD, 32'h8000 + 32'(c * 64),
                 64'd0, 4'(8 + c), 4'd0, 64'd0);
            if (c < 4) check_val("starve_dwin", 64'(obs_dacc), 64'd1);
            else       check_val("starve_iwin", 64'(obs_iacc), 64'd1);
        end
        step(1'b1, 1'b1, 32'h2400, 1'b1, MEM_LOAD, 32'h8400, 64'd0, 4'd13, 4'd0, 64'd0);
        check_val("starve_cleared_dwin", 64'(obs_dacc), 64'd1);
        for (int t = 8; t <= 13; t++) begin
            idle(4'(t), 64'hA0 + 64'(t));
            if (t == 12) check_val("starve_ret_i", 64'(obs_idtag), 64'd12);
        end

        // Accepted store never allocates; its return is spurious
        step(1'b1, 1'b0, 32'd0, 1'b1, MEM_STORE, 32'h4000, 64'h11223344_55667788, 4'd7, 4'd0, 64'd0);
        check_val("st_pdata", obs_pdata,        64'h11223344_55667788);
        check_val("st_dtag",  64'(obs_dtag),    64'd7);
        idle(4'd7, 64'h77);
        check_val("st_spur",  64'(obs_spur),  64'd1);
        check_val("st_cnt",   64'(obs_cnt),   64'd0);
        check_val("st_idtag", 64'(obs_idtag), 64'd0);
        check_val("st_ddtag", 64'(obs_ddtag), 64'd0);
        idle(4'd0, 64'd0);
        check_val("st_spur_pulse", 64'(obs_spur), 64'd0);

        // Return and re-allocate the same tag in one cycle
        step(1'b1, 1'b1, 32'h1100, 1'b0, MEM_NONE, 32'd0, 64'd0, 4'd2, 4'd0, 64'd0);
        step(1'b1, 1'b0, 32'd0, 1'b1, MEM_LOAD, 32'h5000, 64'd0, 4'd2, 4'd2, 64'hAAAA);
        check_val("same_tag_iret", 64'(obs_idtag), 64'd2);
        check_val("same_tag_dacc", 64'(obs_dacc),  64'd1);
        idle(4'd2, 64'hBBBB);
        check_val("same_tag_dret", 64'(obs_ddtag), 64'd2);
        check_val("same_tag_inone", 64'(obs_idtag), 64'd0);

        // Memory rejections: starvation builds, prioritised icache stays prioritised
        for (int c = 0; c < 4; c++) begin
            step(1'b1, 1'b1, 32'h1200, 1'b1, MEM_LOAD, 32'h6000, 64'd0, 4'd0, 4'd0, 64'd0);
            check_val("rej_dacc", 64'(obs_dacc), 64'd0);
            check_val("rej_dtag", 64'(obs_dtag), 64'd0);
            check_val("rej_iacc", 64'(obs_iacc), 64'd0);
        end
        step(1'b1, 1'b1, 32'h1200, 1'b1, MEM_LOAD, 32'h6000, 64'd0, 4'd0, 4'd0, 64'd0);
        check_val("rej_cnt",    64'(obs_cnt),  64'd0);
        check_val("rej_i_addr", 64'(obs_addr), 64'h1200);
        check_val("rej_i_tag",  64'(obs_itag), 64'd0);
        step(1'b1, 1'b1, 32'h1200, 1'b1, MEM_LOAD, 32'h6000, 64'd0, 4'd4, 4'd0, 64'd0);
        check_val("rej_then_iacc", 64'(obs_iacc), 64'd1);
        check_val("rej_then_itag", 64'(obs_itag), 64'd4);
        idle(4'd4, 64'h4444);
        check_val("rej_ret_i", 64'(obs_idtag), 64'd4);

        // Reset mid-operation discards ownership
        step(1'b1, 1'b1, 32'h1300, 1'b0, MEM_NONE, 32'd0, 64'd0, 4'd9, 4'd0, 64'd0);
        step(1'b0, 1'b0, 32'd0, 1'b0, MEM_NONE, 32'd0, 64'd0, 4'd0, 4'd0, 64'd0);
        idle(4'd9, 64'h9999);
        check_val("mid_rst_spur",  64'(obs_spur),  64'd1);
        check_val("mid_rst_idtag", 64'(obs_idtag), 64'd0);
        check_val("mid_rst_cnt",   64'(obs_cnt),   64'd0);
        idle(4'd0, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
